// File: rtl/lmi_dcache_refill.sv
// D-cache miss/refill controller: critical-word-first line fill plus single-word uncached loads.
// Stall asserts combinationally on detect; DC writes land one cycle after each accepted beat; bus side is req/gnt then rdy beats.
module lmi_dcache_refill #(
   parameter int WORD_BITS  = 2,
   parameter int INDEX_BITS = 8,
   parameter int TAG_LO     = 2 + WORD_BITS + INDEX_BITS
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            EN,
   input  logic                            RD,
   input  logic                            KSEG1,
   input  logic                            CMP,
   input  logic [31:0]                     ADDR,
   output logic                            STALL,
   output logic                            BUS_REQ,
   output logic [31:0]                     BUS_ADDR,
   output logic                            BUS_LEN,
   input  logic                            BUS_GNT,
   input  logic                            BUS_RDY,
   input  logic [31:0]                     BUS_DATA,
   input  logic                            BUS_ERR,
   output logic                            DC_WE,
   output logic [INDEX_BITS+WORD_BITS-1:0] DC_WADDR,
   output logic [31:0]                     DC_WDATA,
   output logic                            TAG_WE,
   output logic [31-TAG_LO:0]              TAG_WDATA,
   output logic                            TAG_VAL,
   output logic                            FWD_VALID,
   output logic [31:0]                     FWD_DATA,
   output logic                            ERR
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_UNC, S_TAGWR, S_DONE} state_t;

   localparam logic [WORD_BITS-1:0] LAST_BEAT = '1;

   state_t                          state_q, state_d;
   logic [31:0]                     addr_q;
   logic                            burst_q;
   logic                            err_q;
   logic [WORD_BITS-1:0]            beat_q;
   logic                            dc_we_q;
   logic [INDEX_BITS+WORD_BITS-1:0] dc_waddr_q;
   logic [31:0]                     dc_wdata_q;
   logic [31:0]                     fwd_data_q;

   logic                            miss_det;
   logic                            unc_det;
   logic                            start;
   logic [WORD_BITS-1:0]            word_sel;

   assign miss_det = EN & RD & ~KSEG1 & ~CMP;
   assign unc_det  = EN & RD & KSEG1;
   assign start    = miss_det | unc_det;
   // critical word first: beat k targets (start_word + k), wrapping inside the line
   assign word_sel = addr_q[2 +: WORD_BITS] + beat_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_REQ;
         S_REQ:   if (BUS_GNT) state_d = burst_q ? S_FILL : S_UNC;
         S_FILL:  if (BUS_ERR || (BUS_RDY && beat_q == LAST_BEAT)) state_d = S_TAGWR;
         S_UNC:   if (BUS_ERR || BUS_RDY) state_d = S_DONE;
         S_TAGWR: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      STALL     = 1'b0;
      BUS_REQ   = 1'b0;
      BUS_LEN   = 1'b0;
      TAG_WE    = 1'b0;
      TAG_VAL   = 1'b0;
      FWD_VALID = 1'b0;
      ERR       = 1'b0;
      case (state_q)
         S_IDLE:  STALL = start & ~RESET;
         S_REQ: begin
            STALL   = 1'b1;
            BUS_REQ = 1'b1;
            BUS_LEN = burst_q;
         end
         S_FILL:  STALL = 1'b1;
         S_UNC:   STALL = 1'b1;
         S_TAGWR: begin
            STALL   = 1'b1;
            TAG_WE  = 1'b1;
            TAG_VAL = ~err_q;
            ERR     = err_q;
         end
         S_DONE: begin
            FWD_VALID = ~burst_q & ~err_q;
            ERR       = ~burst_q & err_q;
         end
         default: STALL = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         addr_q     <= '0;
         burst_q    <= 1'b0;
         err_q      <= 1'b0;
         beat_q     <= '0;
         dc_we_q    <= 1'b0;
         dc_waddr_q <= '0;
         dc_wdata_q <= '0;
         fwd_data_q <= '0;
      end else begin
         dc_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q  <= ADDR;
                  burst_q <= miss_det;
                  err_q   <= 1'b0;
                  beat_q  <= '0;
               end
            end
            S_FILL: begin
               // an erroring beat carries no valid data and is never written
               if (BUS_ERR) begin
                  err_q <= 1'b1;
               end else if (BUS_RDY) begin
                  dc_we_q    <= 1'b1;
                  dc_waddr_q <= {addr_q[2+WORD_BITS +: INDEX_BITS], word_sel};
                  dc_wdata_q <= BUS_DATA;
                  beat_q     <= beat_q + 1'b1;
               end
            end
            S_UNC: begin
               if (BUS_ERR) begin
                  err_q <= 1'b1;
               end else if (BUS_RDY) begin
                  fwd_data_q <= BUS_DATA;
               end
            end
            default: dc_we_q <= 1'b0;
         endcase
      end
   end

   assign BUS_ADDR  = addr_q & 32'hFFFF_FFFC;
   assign TAG_WDATA = addr_q[31:TAG_LO];
   assign DC_WE     = dc_we_q;
   assign DC_WADDR  = dc_waddr_q;
   assign DC_WDATA  = dc_wdata_q;
   assign FWD_DATA  = fwd_data_q;

endmodule

// File: tb/tb_lmi_dcache_refill.sv
// Directed bench for lmi_dcache_refill: inputs driven and outputs checked on the falling edge.
module tb_lmi_dcache_refill;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        EN, RD, KSEG1, CMP;
   logic [31:0] ADDR;
   logic        STALL, BUS_REQ, BUS_LEN;
   logic [31:0] BUS_ADDR;
   logic        BUS_GNT, BUS_RDY, BUS_ERR;
   logic [31:0] BUS_DATA;
   logic        DC_WE;
   logic [9:0]  DC_WADDR;
   logic [31:0] DC_WDATA;
   logic        TAG_WE;
   logic [19:0] TAG_WDATA;
   logic        TAG_VAL, FWD_VALID, ERR;
   logic [31:0] FWD_DATA;

   int total = 0;
   int bad   = 0;

   lmi_dcache_refill dut (
      .CLK(CLK), .RESET(RESET), .EN(EN), .RD(RD), .KSEG1(KSEG1), .CMP(CMP), .ADDR(ADDR),
      .STALL(STALL), .BUS_REQ(BUS_REQ), .BUS_ADDR(BUS_ADDR), .BUS_LEN(BUS_LEN),
      .BUS_GNT(BUS_GNT), .BUS_RDY(BUS_RDY), .BUS_DATA(BUS_DATA), .BUS_ERR(BUS_ERR),
      .DC_WE(DC_WE), .DC_WADDR(DC_WADDR), .DC_WDATA(DC_WDATA),
      .TAG_WE(TAG_WE), .TAG_WDATA(TAG_WDATA), .TAG_VAL(TAG_VAL),
      .FWD_VALID(FWD_VALID), .FWD_DATA(FWD_DATA), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic idle_inputs;
      EN = 0; RD = 0; KSEG1 = 0; CMP = 0; ADDR = '0;
      BUS_GNT = 0; BUS_RDY = 0; BUS_ERR = 0; BUS_DATA = '0;
   endtask

   task automatic test_reset;
      @(negedge CLK);
      EN = 1; RD = 1; KSEG1 = 0; CMP = 0; ADDR = 32'h1234_5678;
      #1;
      total++;
      if ({STALL, BUS_REQ, BUS_LEN, DC_WE, TAG_WE, TAG_VAL, FWD_VALID, ERR} !== 8'h00) begin
         bad++;
         $display("FAIL reset_flags: got %b want 00000000",
                  {STALL, BUS_REQ, BUS_LEN, DC_WE, TAG_WE, TAG_VAL, FWD_VALID, ERR});
      end
      total++;
      if ({BUS_ADDR, DC_WDATA, FWD_DATA, DC_WADDR, TAG_WDATA} !== '0) begin
         bad++;
         $display("FAIL reset_data: got %h %h %h %h %h want all zero",
                  BUS_ADDR, DC_WDATA, FWD_DATA, DC_WADDR, TAG_WDATA);
      end
      @(negedge CLK);
      RESET = 0;
      idle_inputs();
   endtask

   task automatic test_hit;
      @(negedge CLK);
      EN = 1; RD = 1; KSEG1 = 0; CMP = 1; ADDR = 32'h0001_2348;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin RD = 0; CMP = 0; end
         #1;
         total++;
         if ({STALL, BUS_REQ, DC_WE, TAG_WE} !== 4'b0000) begin
            bad++;
            $display("FAIL hit_or_store_%0d: got stall/req/dcwe/tagwe=%b want 0000", i,
                     {STALL, BUS_REQ, DC_WE, TAG_WE});
         end
         @(negedge CLK);
      end
      idle_inputs();
   endtask

   task automatic test_miss;
      logic [9:0] ea;
      @(negedge CLK);
      EN = 1; RD = 1; KSEG1 = 0; CMP = 0; ADDR = 32'h0001_2348;
      #1;
      total++;
      if ({STALL, BUS_REQ} !== 2'b10) begin
         bad++;
         $display("FAIL miss_detect: got stall/req=%b want 10", {STALL, BUS_REQ});
      end
      @(negedge CLK);
      EN = 0; RD = 0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({STALL, BUS_REQ, BUS_LEN} !== 3'b111 || BUS_ADDR !== 32'h0001_2348) begin
            bad++;
            $display("FAIL miss_req_%0d: got stall/req/len=%b addr=%h want 111 00012348", i,
                     {STALL, BUS_REQ, BUS_LEN}, BUS_ADDR);
         end
         BUS_GNT = (i == 2);
         @(negedge CLK);
      end
      BUS_GNT = 0;
      for (int k = 0; k < 4; k++) begin
         ea = {8'h34, 2'(k + 1)};
         total++;
         if (k == 0) begin
            if ({STALL, BUS_REQ, DC_WE, TAG_WE} !== 4'b1000) begin
               bad++;
               $display("FAIL miss_fill_start: got stall/req/dcwe/tagwe=%b want 1000",
                        {STALL, BUS_REQ, DC_WE, TAG_WE});
            end
         end else if ({STALL, BUS_REQ, DC_WE, TAG_WE} !== 4'b1010 || DC_WADDR !== ea ||
                      DC_WDATA !== 32'h1000_00A0 + 32'(k - 1)) begin
            bad++;
            $display("FAIL miss_write_%0d: got flags=%b waddr=%h wdata=%h want 1010 %h %h", k - 1,
                     {STALL, BUS_REQ, DC_WE, TAG_WE}, DC_WADDR, DC_WDATA, ea, 32'h1000_00A0 + 32'(k - 1));
         end
         BUS_RDY = 1; BUS_DATA = 32'h1000_00A0 + 32'(k);
         @(negedge CLK);
      end
      BUS_RDY = 0;
      total++;
      if ({STALL, DC_WE, TAG_WE, TAG_VAL, ERR} !== 5'b11110 || DC_WADDR !== 10'h0D1 ||
          DC_WDATA !== 32'h1000_00A3 || TAG_WDATA !== 20'h00012) begin
         bad++;
         $display("FAIL miss_tagwr: got flags=%b waddr=%h wdata=%h tag=%h want 11110 0d1 100000a3 00012",
                  {STALL, DC_WE, TAG_WE, TAG_VAL, ERR}, DC_WADDR, DC_WDATA, TAG_WDATA);
      end
      @(negedge CLK);
      EN = 1; RD = 1; CMP = 0; ADDR = 32'h0001_2348;
      #1;
      total++;
      if ({STALL, BUS_REQ, DC_WE, TAG_WE, FWD_VALID, ERR} !== 6'b000000) begin
         bad++;
         $display("FAIL miss_done: got stall/req/dcwe/tagwe/fwd/err=%b want 000000",
                  {STALL, BUS_REQ, DC_WE, TAG_WE, FWD_VALID, ERR});
      end
      @(negedge CLK);
      CMP = 1;
      #1;
      total++;
      if ({STALL, BUS_REQ} !== 2'b00) begin
         bad++;
         $display("FAIL miss_replay_hit: got stall/req=%b want 00", {STALL, BUS_REQ});
      end
      @(negedge CLK);
      idle_inputs();
   endtask

   task automatic test_uncached;
      @(negedge CLK);
      EN = 1; RD = 1; KSEG1 = 1; CMP = 1; ADDR = 32'hA000_0010;
      #1;
      total++;
      if (STALL !== 1'b1) begin
         bad++;
         $display("FAIL unc_detect: got stall=%b want 1", STALL);
      end
      @(negedge CLK);
      EN = 0; RD = 0; KSEG1 = 0;
      total++;
      if ({BUS_REQ, BUS_LEN} !== 2'b10 || BUS_ADDR !== 32'hA000_0010) begin
         bad++;
         $display("FAIL unc_req: got req/len=%b addr=%h want 10 a0000010", {BUS_REQ, BUS_LEN}, BUS_ADDR);
      end
      BUS_GNT = 1;
      @(negedge CLK);
      BUS_GNT = 0; BUS_RDY = 1; BUS_DATA = 32'hDEAD_BEEF;
      total++;
      if ({STALL, BUS_REQ, DC_WE, FWD_VALID} !== 4'b1000) begin
         bad++;
         $display("FAIL unc_wait: got stall/req/dcwe/fwd=%b want 1000", {STALL, BUS_REQ, DC_WE, FWD_VALID});
      end
      @(negedge CLK);
      BUS_RDY = 0; BUS_DATA = '0;
      total++;
      if ({STALL, DC_WE, TAG_WE, FWD_VALID, ERR} !== 5'b00010 || FWD_DATA !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL unc_done: got flags=%b data=%h want 00010 deadbeef",
                  {STALL, DC_WE, TAG_WE, FWD_VALID, ERR}, FWD_DATA);
      end
      @(negedge CLK);
      total++;
      if ({STALL, DC_WE, TAG_WE, FWD_VALID} !== 4'b0000) begin
         bad++;
         $display("FAIL unc_after: got stall/dcwe/tagwe/fwd=%b want 0000", {STALL, DC_WE, TAG_WE, FWD_VALID});
      end
   endtask

   task automatic test_fill_err;
      @(negedge CLK);
      EN = 1; RD = 1; KSEG1 = 0; CMP = 0; ADDR = 32'h0000_5674;
      @(negedge CLK);
      EN = 0; RD = 0; BUS_GNT = 1;
      @(negedge CLK);
      BUS_GNT = 0; BUS_RDY = 1; BUS_DATA = 32'hE000_0000;
      @(negedge CLK);
      total++;
      if (DC_WE !== 1'b1 || DC_WADDR !== 10'h19D || DC_WDATA !== 32'hE000_0000) begin
         bad++;
         $display("FAIL err_write0: got we=%b waddr=%h wdata=%h want 1 19d e0000000", DC_WE, DC_WADDR, DC_WDATA);
      end
      BUS_DATA = 32'hE000_0001;
      @(negedge CLK);
      total++;
      if (DC_WE !== 1'b1 || DC_WADDR !== 10'h19E || DC_WDATA !== 32'hE000_0001) begin
         bad++;
         $display("FAIL err_write1: got we=%b waddr=%h wdata=%h want 1 19e e0000001", DC_WE, DC_WADDR, DC_WDATA);
      end
      BUS_ERR = 1; BUS_DATA = 32'hE000_0002;
      @(negedge CLK);
      BUS_ERR = 0; BUS_RDY = 0;
      total++;
      if ({STALL, DC_WE, TAG_WE, TAG_VAL, ERR} !== 5'b10101 || TAG_WDATA !== 20'h00005) begin
         bad++;
         $display("FAIL err_tagwr: got stall/dcwe/tagwe/val/err=%b tag=%h want 10101 00005",
                  {STALL, DC_WE, TAG_WE, TAG_VAL, ERR}, TAG_WDATA);
      end
      @(negedge CLK);
      total++;
      if ({STALL, DC_WE, TAG_WE, FWD_VALID, ERR} !== 5'b00000) begin
         bad++;
         $display("FAIL err_done: got stall/dcwe/tagwe/fwd/err=%b want 00000",
                  {STALL, DC_WE, TAG_WE, FWD_VALID, ERR});
      end
      @(negedge CLK);
      total++;
      if ({STALL, BUS_REQ, ERR} !== 3'b000) begin
         bad++;
         $display("FAIL err_idle: got stall/req/err=%b want 000", {STALL, BUS_REQ, ERR});
      end
   endtask

   task automatic test_gaps;
      logic       exp_we;
      logic [9:0] ea;
      @(negedge CLK);
      EN = 1; RD = 1; KSEG1 = 0; CMP = 0; ADDR = 32'h1234_5A3C;
      @(negedge CLK);
      EN = 0; RD = 0; BUS_GNT = 1;
      @(negedge CLK);
      BUS_GNT = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            exp_we = ((i - 1) % 2 == 0);
            ea = {8'hA3, 2'(3 + (i - 1) / 2)};
            total++;
            if (DC_WE !== exp_we || TAG_WE !== (i == 7) ||
                (exp_we && (DC_WADDR !== ea || DC_WDATA !== 32'hC0DE_0000 + 32'((i - 1) / 2)))) begin
               bad++;
               $display("FAIL gap_cycle_%0d: got we=%b tagwe=%b waddr=%h wdata=%h want we=%b tagwe=%b waddr=%h",
                        i, DC_WE, TAG_WE, DC_WADDR, DC_WDATA, exp_we, (i == 7), ea);
            end
         end
         BUS_RDY = (i % 2 == 0) && (i < 7);
         BUS_DATA = 32'hC0DE_0000 + 32'(i / 2);
         @(negedge CLK);
      end
      BUS_RDY = 0;
      total++;
      if ({STALL, TAG_WE, DC_WE} !== 3'b000) begin
         bad++;
         $display("FAIL gap_done: got stall/tagwe/dcwe=%b want 000", {STALL, TAG_WE, DC_WE});
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid;
      logic [9:0] ea;
      @(negedge CLK);
      EN = 1; RD = 1; KSEG1 = 0; CMP = 0; ADDR = 32'h0000_1110;
      @(negedge CLK);
      EN = 0; RD = 0; BUS_GNT = 1;
      @(negedge CLK);
      BUS_GNT = 0; BUS_RDY = 1; BUS_DATA = 32'h5555_0000;
      @(negedge CLK);
      BUS_DATA = 32'h5555_0001;
      @(negedge CLK);
      total++;
      if ({STALL, DC_WE} !== 2'b11 || DC_WADDR !== 10'h045) begin
         bad++;
         $display("FAIL rst_pre: got stall/dcwe=%b waddr=%h want 11 045", {STALL, DC_WE}, DC_WADDR);
      end
      BUS_DATA = 32'h5555_0002;
      #2 RESET = 1;
      #1;
      total++;
      if ({STALL, BUS_REQ, BUS_LEN, DC_WE, TAG_WE, TAG_VAL, FWD_VALID, ERR} !== 8'h00 ||
          {BUS_ADDR, DC_WDATA, DC_WADDR, TAG_WDATA} !== '0) begin
         bad++;
         $display("FAIL rst_async: got flags=%b addr=%h wdata=%h waddr=%h want all zero",
                  {STALL, BUS_REQ, BUS_LEN, DC_WE, TAG_WE, TAG_VAL, FWD_VALID, ERR}, BUS_ADDR, DC_WDATA, DC_WADDR);
      end
      @(negedge CLK);
      idle_inputs();
      @(negedge CLK);
      RESET = 0;
      EN = 1; RD = 1; CMP = 0; ADDR = 32'h0003_4568;
      @(negedge CLK);
      EN = 0; RD = 0;
      total++;
      if ({BUS_REQ, BUS_LEN} !== 2'b11 || BUS_ADDR !== 32'h0003_4568) begin
         bad++;
         $display("FAIL rst_new_req: got req/len=%b addr=%h want 11 00034568", {BUS_REQ, BUS_LEN}, BUS_ADDR);
      end
      BUS_GNT = 1;
      @(negedge CLK);
      BUS_GNT = 0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            ea = {8'h56, 2'(k + 1)};
            total++;
            if (DC_WE !== 1'b1 || DC_WADDR !== ea || DC_WDATA !== 32'h7700_0000 + 32'(k - 1) ||
                TAG_WE !== (k == 4)) begin
               bad++;
               $display("FAIL rst_new_write_%0d: got we=%b waddr=%h wdata=%h tagwe=%b want 1 %h %h %b", k - 1,
                        DC_WE, DC_WADDR, DC_WDATA, TAG_WE, ea, 32'h7700_0000 + 32'(k - 1), (k == 4));
            end
         end
         BUS_RDY = (k < 4); BUS_DATA = 32'h7700_0000 + 32'(k);
         @(negedge CLK) ;
         if (k == 3) begin
            BUS_RDY = 0;
         end
      end
      total++;
      if ({STALL, TAG_WE, DC_WE} !== 3'b000) begin
         bad++;
         $display("FAIL rst_new_done: got stall/tagwe/dcwe=%b want 000", {STALL, TAG_WE, DC_WE});
      end
      @(negedge CLK);
   endtask

   initial begin
      RESET = 1;
      idle_inputs();
      test_reset();
      test_hit();
      test_miss();
      test_uncached();
      test_fill_err();
      test_gaps();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   final begin
      if (total == 0) $display("test done: total=%0d bad=%0d", total, bad);
   end

endmodule

// File: doc/lmi_dcache_refill.md
# lmi_dcache_refill

Data-cache miss/refill controller that sits directly downstream of the D-cache tag comparator. It consumes the per-access hit indication and stalls the pipeline on a cacheable load miss. It fetches the missed line from the memory bus in critical-word-first wrap order, writes the data RAM and then the tag/valid RAM, and also performs single-word uncached (KSEG1) loads, forwarding the returned word to the pipeline.

## Interface
- WORD_BITS, 2, log2 of words per line (line = 4 words).
- INDEX_BITS, 8, cache index width.
- TAG_LO, 2+WORD_BITS+INDEX_BITS, lowest tag address bit; tag = ADDR[31:TAG_LO].
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  D-side access valid this cycle.
- RD  in  1  access is a load.
- KSEG1  in  1  access is uncached.
- CMP  in  1  tag comparator hit (already forced 1 for KSEG1).
- ADDR  in  32  access byte address.
- STALL  out  1  hold pipeline.
- BUS_REQ  out  1  bus read request.
- BUS_ADDR  out  32  word-aligned start address.
- BUS_LEN  out  1  0 = single word, 1 = line burst.
- BUS_GNT  in  1  request accepted.
- BUS_RDY  in  1  data beat valid.
- BUS_DATA  in  32  beat data.
- BUS_ERR  in  1  bus error; terminates the transfer, and no further beats follow.
- DC_WE  out  1  data RAM write.
- DC_WADDR  out  INDEX_BITS+WORD_BITS  {index, word}.
- DC_WDATA  out  32  data RAM write data.
- TAG_WE  out  1  tag RAM write.
- TAG_WDATA  out  32-TAG_LO  tag written.
- TAG_VAL  out  1  valid bit written.
- FWD_VALID  out  1  uncached load data valid.
- FWD_DATA  out  32  uncached load data.
- ERR  out  1  one-cycle bus-error pulse.

## Operation
- States: IDLE, REQ, FILL, UNC, TAGWR, DONE.
- IDLE
  - Cached miss = EN & RD & ~KSEG1 & ~CMP: latch ADDR and go to REQ with BUS_LEN=1.
  - Uncached load = EN & RD & KSEG1: latch ADDR and go to REQ with BUS_LEN=0.
  - Stores and hits: no action.
- REQ
  - BUS_REQ=1 and BUS_ADDR={latched ADDR[31:2],2'b00} are held stable until BUS_GNT is sampled high.
  - On BUS_GNT, go to FILL (burst) or UNC (single).
  - BUS_REQ drops in the cycle after GNT.
- FILL
  - A beat counter counts BUS_RDY beats.
  - Beat k writes word (start_word + k) mod 2^WORD_BITS, wrapping at line end.
  - After beat 2^WORD_BITS-1, go to TAGWR.
- TAGWR
  - One cycle: TAG_WE=1, TAG_WDATA=latched tag, TAG_VAL=1.
  - Then go to DONE.
- UNC
  - On BUS_RDY, register BUS_DATA into FWD_DATA and go to DONE.
  - No RAM writes.
- DONE
  - One cycle, then IDLE.
  - FWD_VALID=1 only if the transfer was uncached and had no error.
  - Miss detection is suppressed in DONE: the access presented here is the replayed or retired one. A cached replay hits because the tag was just written.
- BUS_ERR in FILL
  - No DC write for that beat.
  - Go to TAGWR with TAG_VAL=0, invalidating the partially filled line.
  - ERR=1 in the TAGWR cycle.
- BUS_ERR in UNC
  - Go to DONE with FWD_VALID=0 and ERR=1.
- BUS_ERR in REQ is ignored.
- RESET at any time: state IDLE, counters 0, all outputs 0; any pending bus transaction is abandoned.

## Timing
- STALL = (IDLE & miss-or-uncached detect), combinational, | (state ∈ {REQ, FILL, UNC, TAGWR}). STALL is 0 in DONE.
- DC writes are registered: a beat accepted in cycle t gives DC_WE=1 with DC_WADDR/DC_WDATA in cycle t+1.
- The last data write coincides with the TAGWR cycle.
- Cached miss, zero-wait bus (GNT in the first REQ cycle, beats back-to-back):
  - detect c0
  - REQ c1
  - beats c2–c5
  - TAGWR c6
  - DONE c7 (STALL low)
  - Total stall 7 cycles.
- Uncached, zero-wait bus: detect c0, REQ c1, beat c2, DONE c3 with FWD_VALID=1.
- Gaps in BUS_RDY during FILL extend FILL and produce no DC_WE cycles.
- Reset values: STALL, BUS_REQ, BUS_LEN, DC_WE, TAG_WE, TAG_VAL, FWD_VALID and ERR are 0; all address and data outputs are 0.

## Test plan
- Cached load hit (EN=RD=CMP=1, KSEG1=0) → STALL=0, no BUS_REQ, no writes.
- Miss at ADDR=0x0001_2348 (word 2, index 0x34), GNT after 2 cycles, back-to-back RDY with data A,B,C,D:
  - BUS_ADDR=0x0001_2348, BUS_LEN=1.
  - DC writes {0x34,2}=A, {0x34,3}=B, {0x34,0}=C, {0x34,1}=D.
  - TAG_WE with tag 0x00012 and VAL=1.
  - STALL falls in DONE.
- Uncached load at 0xA000_0010 returning 0xDEADBEEF → BUS_LEN=0, no DC_WE/TAG_WE, FWD_VALID=1 and FWD_DATA=0xDEADBEEF for exactly one cycle.
- Miss with BUS_ERR on beat 2 → two DC writes only, TAG_WE with TAG_VAL=0, ERR pulses once, return to IDLE.
- Burst with one idle cycle between every beat → DC_WE only on cycles following a beat, correct wrap order, TAGWR follows the 4th write.
- RESET asserted mid-FILL after 2 beats → all outputs 0 immediately (asynchronous). After release, a new miss restarts at beat 0 from the new ADDR.
